// File: rtl/pixel_stream_merger.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_merger
// Brief    : Merges interleaved per-core RGB pixels into one raster stream.
// Revision : 1.0
// ============================================================================
module pixel_stream_merger #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              active_cores,
    input  logic [12:0]             image_width,
    input  logic [12:0]             image_height,
    input  logic [NUM_CORES-1:0]    in_valid,
    output logic [NUM_CORES-1:0]    in_ready,
    input  logic [NUM_CORES*24-1:0] in_rgb,
    input  logic [NUM_CORES*32-1:0] in_index,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [23:0]             out_rgb,
    output logic                    out_sof,
    output logic                    out_eol,
    output logic                    seq_error,
    output logic [15:0]             frames_done
);
    localparam int         AW          = $clog2(FIFO_DEPTH);
    localparam logic [3:0] c_MAX_CORES = 4'(NUM_CORES);
    localparam logic [0:0] c_LOAD      = 1'b0;
    localparam logic [0:0] c_RUN       = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic        w_is_load;
    logic        w_is_run;
    logic [3:0]  r_active;
    logic [12:0] r_width;
    logic [12:0] r_height;
    logic [2:0]  r_sel;
    logic [12:0] r_x;
    logic [12:0] r_y;
    logic [25:0] r_pix_cnt;
    logic        r_out_valid;
    logic [23:0] r_out_rgb;
    logic        r_out_sof;
    logic        r_out_eol;
    logic        r_out_last;
    logic        r_seq_error;
    logic [15:0] r_frames_done;
    logic [7:0]  w_empty;
    logic [23:0] w_head_rgb [8];
    logic [25:0] w_head_idx [8];
    logic        w_load;
    logic        w_out_hs;
    logic        w_frame_end;
    logic        w_sel_empty;
    logic [23:0] w_sel_rgb;
    logic [25:0] w_sel_idx;
    logic        w_at_eol;

    // Lanes beyond NUM_CORES read as permanently empty so sel can index all 8 slots.
    for (genvar k = 0; k < 8; k++) begin : g_core
        if (k < NUM_CORES) begin : g_fifo
            logic [49:0] r_mem [FIFO_DEPTH];
            logic [AW:0] r_wptr;
            logic [AW:0] r_rptr;
            logic        w_full;
            logic        w_push;
            logic        w_pop;
            logic        w_unused_idx_hi;

            assign w_full          = (r_wptr[AW] != r_rptr[AW]) &&
                                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
            assign w_push          = in_valid[k] && !w_full;
            assign w_pop           = w_load && (r_sel == 3'(k));
            assign in_ready[k]     = !w_full;
            assign w_empty[k]      = (r_wptr == r_rptr);
            assign {w_head_rgb[k], w_head_idx[k]} = r_mem[r_rptr[AW-1:0]];
            assign w_unused_idx_hi = ^in_index[32*k+26 +: 6];

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wptr[AW-1:0]] <= {in_rgb[24*k +: 24], in_index[32*k +: 26]};
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_push) r_wptr <= r_wptr + 1'b1;
                    if (w_pop)  r_rptr <= r_rptr + 1'b1;
                end
            end
        end else begin : g_absent
            assign w_empty[k]    = 1'b1;
            assign w_head_rgb[k] = '0;
            assign w_head_idx[k] = '0;
        end
    end

    assign w_sel_empty = w_empty[r_sel];
    assign w_sel_rgb   = w_head_rgb[r_sel];
    assign w_sel_idx   = w_head_idx[r_sel];
    assign w_at_eol    = (r_x == r_width - 13'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_LOAD;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_LOAD:  w_state_nxt = c_RUN;
            c_RUN:   if (w_frame_end) w_state_nxt = c_LOAD;
            default: w_state_nxt = c_LOAD;
        endcase
    end

    always_comb begin
        w_is_load = (r_state == c_LOAD);
        w_is_run  = (r_state == c_RUN);
    end

    // The frame's last pixel blocks further loads so the next frame starts after LOAD.
    assign w_out_hs    = r_out_valid && out_ready;
    assign w_frame_end = w_is_run && w_out_hs && r_out_last;
    assign w_load      = w_is_run && !w_sel_empty &&
                         (!r_out_valid || (out_ready && !r_out_last));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active  <= 4'd1;
            r_width   <= 13'd1;
            r_height  <= 13'd1;
            r_sel     <= 3'd0;
            r_x       <= 13'd0;
            r_y       <= 13'd0;
            r_pix_cnt <= 26'd0;
        end else if (w_is_load) begin
            if (active_cores == 4'd0)             r_active <= 4'd1;
            else if (active_cores > c_MAX_CORES)  r_active <= c_MAX_CORES;
            else                                  r_active <= active_cores;
            r_width   <= (image_width == 13'd0)  ? 13'd1 : image_width;
            r_height  <= (image_height == 13'd0) ? 13'd1 : image_height;
            r_sel     <= 3'd0;
            r_x       <= 13'd0;
            r_y       <= 13'd0;
            r_pix_cnt <= 26'd0;
        end else if (w_load) begin
            r_sel <= ({1'b0, r_sel} == r_active - 4'd1) ? 3'd0 : r_sel + 3'd1;
            if (w_at_eol) begin
                r_x <= 13'd0;
                r_y <= (r_y == r_height - 13'd1) ? 13'd0 : r_y + 13'd1;
            end else begin
                r_x <= r_x + 13'd1;
            end
            r_pix_cnt <= r_pix_cnt + 26'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_rgb     <= 24'd0;
            r_out_sof     <= 1'b0;
            r_out_eol     <= 1'b0;
            r_out_last    <= 1'b0;
            r_seq_error   <= 1'b0;
            r_frames_done <= 16'd0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_rgb   <= w_sel_rgb;
                r_out_sof   <= (r_x == 13'd0) && (r_y == 13'd0);
                r_out_eol   <= w_at_eol;
                r_out_last  <= w_at_eol && (r_y == r_height - 13'd1);
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_load && (w_sel_idx != r_pix_cnt)) r_seq_error <= 1'b1;
            if (w_frame_end) r_frames_done <= r_frames_done + 16'd1;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_rgb     = r_out_rgb;
    assign out_sof     = r_out_sof;
    assign out_eol     = r_out_eol;
    assign seq_error   = r_seq_error;
    assign frames_done = r_frames_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_merger
// Brief    : Randomised scoreboard bench for pixel_stream_merger.
// Revision : 1.0
// ============================================================================
module tb_pixel_stream_merger;
    localparam int NC = 4;
    localparam int FD = 4;

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
        logic        last;
        logic        err;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [3:0]     active_cores = 4'd4;
    logic [12:0]    image_width = 13'd4;
    logic [12:0]    image_height = 13'd2;
    logic [NC-1:0]  in_valid;
    logic [NC-1:0]  in_ready;
    logic [NC*24-1:0] in_rgb;
    logic [NC*32-1:0] in_index;
    logic           out_valid;
    logic           out_ready;
    logic [23:0]    out_rgb;
    logic           out_sof;
    logic           out_eol;
    logic           seq_error;
    logic [15:0]    frames_done;

    exp_t        exp_q[$];
    logic [23:0] src_rgb [NC][256];
    logic [31:0] src_idx [NC][256];
    int          wr_cnt [NC];
    int          rd_cnt [NC];
    int          hold [NC];
    int          checks = 0;
    int          errors = 0;
    int          out_cnt = 0;
    int          exp_frames = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    bit          drv_en = 1'b0;
    bit          gap_en = 1'b0;
    bit          cum_err = 1'b0;
    bit          stalled = 1'b0;
    logic [25:0] prev_out;
    exp_t        mon_e;

    pixel_stream_merger #(.NUM_CORES(NC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .active_cores(active_cores),
        .image_width(image_width), .image_height(image_height),
        .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb), .in_index(in_index),
        .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb),
        .out_sof(out_sof), .out_eol(out_eol), .seq_error(seq_error),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: pixel i of a frame belongs to core i % A and carries index i.
    task automatic gen_frames(input int act, input int w, input int h, input int nf,
                              input int bad_pix, input int bad_val);
        int a, ww, hh, n, c;
        exp_t e;
        a  = (act == 0) ? 1 : ((act > NC) ? NC : act);
        ww = (w == 0) ? 1 : w;
        hh = (h == 0) ? 1 : h;
        n  = ww * hh;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < n; i++) begin
                c = i % a;
                src_rgb[c][wr_cnt[c]] = 24'($urandom);
                if (f == 0 && i == bad_pix) begin
                    src_idx[c][wr_cnt[c]] = 32'(bad_val);
                    cum_err = 1'b1;
                end else begin
                    src_idx[c][wr_cnt[c]] = 32'(i) | ($urandom & 32'hFC00_0000);
                end
                e.rgb  = src_rgb[c][wr_cnt[c]];
                e.sof  = (i == 0);
                e.eol  = ((i % ww) == ww - 1);
                e.last = (i == n - 1);
                e.err  = cum_err;
                exp_q.push_back(e);
                wr_cnt[c]++;
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int k = 0; k < NC; k++) begin
            wr_cnt[k] = 0;
            rd_cnt[k] = 0;
            hold[k]   = 0;
        end
        exp_frames = 0;
        cum_err    = 1'b0;
        out_cnt    = 0;
    endtask

    task automatic start_test(input int act, input int w, input int h, input int rmode, input bit gap);
        @(posedge clk); #2;
        drv_en       = 1'b0;
        reset        = 1'b1;
        active_cores = 4'(act);
        image_width  = 13'(w);
        image_height = 13'(h);
        rdy_mode     = rmode;
        gap_en       = gap;
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_done(input string name, input int nf);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pixels outstanding expected 0", name, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #2;
        chk({name, "_frames"}, 64'(frames_done), 64'(nf));
        chk({name, "_seq_error"}, 64'(seq_error), 64'(cum_err));
        chk({name, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    // Sink, monitor and core drivers, all evaluated on the falling edge.
    initial begin
        in_valid  = '0;
        in_rgb    = '0;
        in_index  = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (!out_valid || {out_rgb, out_sof, out_eol} != prev_out) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b %h expected v=1 %h",
                                 out_valid, {out_rgb, out_sof, out_eol}, prev_out);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_pixel: got rgb=%h expected no pixel", out_rgb);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if ({out_rgb, out_sof, out_eol, seq_error} !=
                                {mon_e.rgb, mon_e.sof, mon_e.eol, mon_e.err} ||
                                frames_done != 16'(exp_frames)) begin
                            errors++;
                            $display("FAIL pixel%0d: got rgb=%h sof=%0b eol=%0b err=%0b fr=%0d expected rgb=%h sof=%0b eol=%0b err=%0b fr=%0d",
                                     out_cnt, out_rgb, out_sof, out_eol, seq_error, frames_done,
                                     mon_e.rgb, mon_e.sof, mon_e.eol, mon_e.err, exp_frames);
                        end
                        if (mon_e.last) exp_frames++;
                        out_cnt++;
                    end
                end
                stalled  = out_valid && !out_ready;
                prev_out = {out_rgb, out_sof, out_eol};
            end
            for (int k = 0; k < NC; k++) begin
                if (drv_en && hold[k] > 0) hold[k]--;
                if (drv_en && !reset && hold[k] == 0 && rd_cnt[k] < wr_cnt[k] &&
                        (!gap_en || $urandom_range(0, 3) != 0)) begin
                    in_valid[k]          = 1'b1;
                    in_rgb[24*k +: 24]   = src_rgb[k][rd_cnt[k]];
                    in_index[32*k +: 32] = src_idx[k][rd_cnt[k]];
                    if (in_ready[k]) rd_cnt[k]++;
                end else begin
                    in_valid[k]          = 1'b0;
                    in_rgb[24*k +: 24]   = 24'($urandom);
                    in_index[32*k +: 32] = $urandom;
                end
            end
        end
    end

    initial begin
        int t;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_rgb", 64'(out_rgb), 64'd0);
        chk("rst_markers", 64'({out_sof, out_eol}), 64'd0);
        chk("rst_seq_error", 64'(seq_error), 64'd0);
        chk("rst_frames_done", 64'(frames_done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'hF);

        start_test(4, 4, 2, 0, 1'b0);
        gen_frames(4, 4, 2, 1, -1, 0);
        drv_en = 1'b1;
        wait_done("basic", 1);

        start_test(4, 4, 5, 0, 1'b0);
        gen_frames(4, 4, 5, 1, -1, 0);
        hold[1] = 20;
        drv_en  = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        chk("stall_in_ready", 64'(in_ready), 64'h2);
        chk("stall_out_valid", 64'(out_valid), 64'd0);
        chk("stall_out_count", 64'(out_cnt), 64'd1);
        wait_done("core1_delay", 1);

        start_test(3, 3, 3, 1, 1'b1);
        gen_frames(3, 3, 3, 2, -1, 0);
        drv_en = 1'b1;
        wait_done("ready_toggle", 2);

        start_test(0, 3, 2, 2, 1'b1);
        gen_frames(0, 3, 2, 1, -1, 0);
        drv_en = 1'b1;
        wait_done("active0", 1);

        start_test(7, 5, 2, 2, 1'b1);
        gen_frames(7, 5, 2, 2, -1, 0);
        drv_en = 1'b1;
        wait_done("active7", 2);

        start_test(2, 0, 4, 0, 1'b1);
        gen_frames(2, 0, 4, 1, -1, 0);
        drv_en = 1'b1;
        wait_done("width0", 1);

        start_test(4, 1, 1, 2, 1'b0);
        gen_frames(4, 1, 1, 3, -1, 0);
        drv_en = 1'b1;
        wait_done("one_by_one", 3);

        start_test(4, 4, 2, 0, 1'b0);
        gen_frames(4, 4, 2, 1, 2, 9);
        gen_frames(4, 4, 2, 1, -1, 0);
        drv_en = 1'b1;
        wait_done("seq_error", 2);

        start_test(4, 4, 2, 0, 1'b0);
        gen_frames(4, 4, 2, 1, -1, 0);
        drv_en = 1'b1;
        t = 0;
        while (out_cnt < 5 && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("midrst_reached", 64'(out_cnt >= 5), 64'd1);
        chk("midrst_presenting", 64'(out_valid), 64'd1);
        drv_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_rgb", 64'(out_rgb), 64'd0);
        chk("midrst_markers", 64'({out_sof, out_eol}), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'hF);
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("midrst_frames_done", 64'(frames_done), 64'd0);
        gen_frames(4, 4, 2, 1, -1, 0);
        drv_en = 1'b1;
        wait_done("after_midrst", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pixel_stream_merger.md
# pixel_stream_merger

Parametrised N-core pixel merger for the ray-tracing pipeline: collects RGB results from up to `NUM_CORES` ray-processor cores, each core rendering every Nth pixel of the frame, and emits one raster-ordered video stream with start-of-frame and end-of-line markers. It sits between the ray processors and the external video-stream sink and generalises the two-core pixel buffer. It adds a runtime active-core count, per-core FIFOs, pixel-index checking and a frame counter.

## Interface
- `NUM_CORES`, 4: physical core inputs, 1..8.
- `FIFO_DEPTH`, 4: per-core FIFO entries, power of two, ≥2.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `active_cores` in 4: cores in use; latched in LOAD state only.
- `image_width` in 13: pixels per line; latched in LOAD.
- `image_height` in 13: lines per frame; latched in LOAD.
- `in_valid` in NUM_CORES: per-core pixel valid.
- `in_ready` out NUM_CORES: per-core accept; equals FIFO not full.
- `in_rgb` in NUM_CORES*24: core k at bits [24k+23:24k], {r,g,b}.
- `in_index` in NUM_CORES*32: raster pixel index of core k's pixel.
- `out_valid` out 1: output pixel valid.
- `out_ready` in 1: sink ready.
- `out_rgb` out 24: output pixel {r,g,b}.
- `out_sof` out 1: first pixel of frame, qualified by `out_valid`.
- `out_eol` out 1: last pixel of line, qualified by `out_valid`.
- `seq_error` out 1: sticky; head index mismatched expected index.
- `frames_done` out 16: completed frames, wraps modulo 2^16.

## Operation
- Handshakes: input transfer on `in_valid[k] && in_ready[k]`. Output transfer on `out_valid && out_ready`.
- FIFO behaviour:
  - `in_ready[k]` = !full. It does not depend on a same-cycle pop.
  - Pushes are ignored while `in_ready[k]`=0.
  - Core k ≥ latched active count: FIFO still accepts, but is never read.
- FSM:
  - States: LOAD, RUN. LOAD is entered on reset release.
  - LOAD lasts one cycle and latches config, clamped as follows: `active_cores` 0→1, >NUM_CORES→NUM_CORES; width or height 0→1.
  - LOAD clears `sel`, x, y and `pix_cnt`. Next state is RUN.
  - RUN→LOAD on the output handshake of pixel (x=W-1, y=H-1). `frames_done` increments on that same edge.
- Merge:
  - `sel` (3 bits) names the core owning the next pixel.
  - In RUN, the output register loads from FIFO[`sel`] head when FIFO[`sel`] is non-empty and (`out_valid`=0 or handshake this cycle). That FIFO pops on the same edge.
  - On each load, `sel` advances by 1, wrapping from active−1 to 0.
  - No load occurs in LOAD state.
- Markers:
  - `out_sof` = (x==0 && y==0) for the loaded pixel.
  - `out_eol` = (x==W-1) for the loaded pixel.
  - x and y advance on each load: x wraps at W-1, then y increments.
- Index check:
  - `pix_cnt` (26 bits) increments per load.
  - If `in_index[25:0]` at the FIFO head ≠ `pix_cnt`, `seq_error` is set. The pixel is still output unchanged.
  - `seq_error` clears only on reset.

## Timing
- Reset values:
  - `out_valid`, `out_rgb`, `out_sof`, `out_eol`, `seq_error`, `frames_done`: 0.
  - All FIFOs empty, so `in_ready` is all 1s during and after reset.
  - FSM enters LOAD.
- Latency:
  - Input handshake at edge t: entry is visible in the FIFO after t.
  - Output register loads at edge t+1, so `out_valid` is high in cycle t+1 (minimum 2 edges).
  - Exception: the first pixel after reset, or after frame end, waits one extra cycle for LOAD.
- Throughput: one pixel per cycle when all active FIFOs are non-empty and `out_ready`=1.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_rgb`, `out_sof` and `out_eol` hold stable.
- Stall: if FIFO[`sel`] is empty, the output stalls even when other FIFOs are full. Those cores see `in_ready`=0.
- Mid-frame reset: FIFOs are flushed, all counters cleared, and the partial frame is discarded.
- Single-core mode (active=1): `sel` stays at 0.
- 1×1 frame: the first pixel carries both `out_sof` and `out_eol`.

## Test plan
- NUM_CORES=4, active=4, 4×2 image, cores supply indices 0..7 in order, `out_ready`=1:
  - Pixels 0..7 are output in order.
  - `out_sof` is high only on pixel 0; `out_eol` on pixels 3 and 7.
  - `frames_done`=1 and `seq_error`=0.
- Core 1 delayed 20 cycles, FIFO_DEPTH=4: output stalls after pixel 0 and `in_ready` for cores 0, 2 and 3 falls when their FIFOs hold 4. Output resumes in order once core 1 delivers.
- `out_ready` toggles 1,0,0,1 on every pixel: no pixel is lost or duplicated, and the data is stable while stalled.
- Latched-config clamping:
  - active=0 → all pixels are taken from core 0.
  - active=7 with NUM_CORES=4 → 4 cores are used.
  - width=0 → every pixel has `out_eol`=1.
- Core 2 sends index 9 where 2 is expected: `seq_error` is 1 from the next cycle, stays set across frames, and the pixel data is still output.
- `reset` asserted mid-frame at pixel 5 → outputs are 0 in the same cycle. After release, a fresh frame starts with `out_sof` on index 0 and `frames_done` is 0.
